// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, ALU-class and opcode encodings for the MIPS multi-cycle controller
package ctrl_pkg;
  typedef enum logic [4:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WAIT, S_MEM_WB, S_MEM_WRITE,
    S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
  } state_t;
  typedef enum logic [1:0] {ADD = 2'd0, FUNCT = 2'd1, IMM = 2'd2, BRANCH = 2'd3} alu_op_t;
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_HALT   = 6'h3F;
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  function automatic state_t decode_class(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_RTYPE ? (fn == FUNCT_JR ? S_JR : S_R_EXEC) :
           (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
           (op >= OP_ADDIU && op <= OP_XORI) ? S_I_EXEC :
           (op == OP_REGIMM || (op >= OP_BEQ && op <= OP_BGTZ)) ? S_BRANCH :
           op == OP_J ? S_JUMP :
           op == OP_JAL ? S_JAL :
           op == OP_HALT ? S_HALT : S_FETCH;
  endfunction
endpackage

// File: rtl/mips_controller.sv
// mips_controller: multi-cycle Moore control FSM driving the MIPS datapath strobes
module mips_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] ir_opcode,
  input  logic [5:0] ir_funct,
  input  logic       branch_taken,
  output logic       pc_write_en,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       jump_and_link,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output alu_op_t    alu_op,
  output logic [1:0] pc_source,
  output logic       is_signed,
  output logic       halted
);
  state_t state, next_state, out_state;
  logic pc_write, pc_write_cond;
  always_ff @(posedge clk)
    state <= rst ? S_FETCH : next_state;
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:      next_state = S_FETCH_WAIT;
      S_FETCH_WAIT: next_state = S_DECODE;
      S_DECODE:     next_state = decode_class(ir_opcode, ir_funct);
      S_R_EXEC:     next_state = S_R_WB;
      S_I_EXEC:     next_state = S_I_WB;
      S_MEM_ADDR:   next_state = ir_opcode == OP_SW ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:   next_state = S_MEM_WAIT;
      S_MEM_WAIT:   next_state = S_MEM_WB;
      S_HALT:       next_state = S_HALT;
      default:      next_state = S_FETCH;
    endcase
  end
  // reset masks the decode so every strobe reads as FETCH while rst is high
  assign out_state = rst ? S_FETCH : state;
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    jump_and_link = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = ADD;
    pc_source = 2'b00;
    is_signed = 1'b0;
    halted = 1'b0;
    case (out_state)
      S_FETCH_WAIT: begin
        ir_write = 1'b1;
        alu_src_b = 2'b01;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        is_signed = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = FUNCT;
      end
      S_R_WB: begin
        reg_dst = 1'b1;
        reg_write = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = IMM;
        is_signed = !(ir_opcode inside {OP_ANDI, OP_ORI, OP_XORI});
      end
      S_I_WB: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        is_signed = 1'b1;
      end
      S_MEM_READ, S_MEM_WAIT: i_or_d = 1'b1;
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = BRANCH;
        pc_source = 2'b01;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write = 1'b1;
      end
      S_JAL: begin
        pc_source = 2'b10;
        pc_write = 1'b1;
        jump_and_link = 1'b1;
        reg_write = 1'b1;
      end
      S_JR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        pc_write = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end
  assign pc_write_en = pc_write | (pc_write_cond & branch_taken);
endmodule

// File: tb/tb_mips_controller.sv
// tb_mips_controller: directed scoreboard bench, one expected control word per cycle
module tb_mips_controller;
  import ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] ir_opcode = '0;
  logic [5:0] ir_funct = '0;
  logic branch_taken = 1'b0;
  logic pc_write_en, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic jump_and_link, alu_src_a, is_signed, halted;
  logic [1:0] alu_src_b, pc_source;
  alu_op_t alu_op;
  logic mon_en = 1'b0;
  logic [16:0] q[$];
  logic [16:0] got, want;
  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  always #5 clk = ~clk;
  mips_controller dut (
    .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .ir_funct(ir_funct),
    .branch_taken(branch_taken), .pc_write_en(pc_write_en), .i_or_d(i_or_d),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .jump_and_link(jump_and_link),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .is_signed(is_signed), .halted(halted)
  );
  // word layout: pwe iod mw irw m2r rd rw jal asa asb[2] aop[2] psrc[2] sgn hlt
  function automatic logic [16:0] v(input logic pwe, iod, mw, irw, m2r, rd, rw, jl, asa,
                                    input logic [1:0] asb, aop, ps, input logic sg, h);
    return {pwe, iod, mw, irw, m2r, rd, rw, jl, asa, asb, aop, ps, sg, h};
  endfunction
  localparam logic [16:0] E_F     = '0;
  localparam logic [16:0] E_FW    = 17'b1_0_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_D     = 17'b0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [16:0] E_RE    = 17'b0_0_0_0_0_0_0_0_1_00_01_00_0_0;
  localparam logic [16:0] E_RWB   = 17'b0_0_0_0_0_1_1_0_0_00_00_00_0_0;
  localparam logic [16:0] E_IWB   = 17'b0_0_0_0_0_0_1_0_0_00_00_00_0_0;
  localparam logic [16:0] E_MA    = 17'b0_0_0_0_0_0_0_0_1_10_00_00_1_0;
  localparam logic [16:0] E_MR    = 17'b0_1_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_MWB   = 17'b0_0_0_0_1_0_1_0_0_00_00_00_0_0;
  localparam logic [16:0] E_MW    = 17'b0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_J     = 17'b1_0_0_0_0_0_0_0_0_00_00_10_0_0;
  localparam logic [16:0] E_JAL   = 17'b1_0_0_0_0_0_1_1_0_00_00_10_0_0;
  localparam logic [16:0] E_JR    = 17'b1_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] E_H     = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_1;
  assign got = v(pc_write_en, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                 jump_and_link, alu_src_a, alu_src_b, alu_op, pc_source, is_signed, halted);
  always @(negedge clk) begin
    if (mon_en) begin
      cyc_no++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL underflow cycle %0d: no expected word queued, got %b", cyc_no, got);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL ctrl cycle %0d op=%h: got %b want %b", cyc_no, ir_opcode, got, want);
        end
      end
    end
  end
  task automatic cyc(input logic [16:0] e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic pre(input logic [5:0] op, input logic [5:0] fn);
    ir_opcode = op;
    ir_funct = fn;
    cyc(E_F);
    cyc(E_FW);
    cyc(E_D);
  endtask
  task automatic iexec(input logic [5:0] op, input logic sg);
    pre(op, 6'h00);
    cyc(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, sg, 0));
    cyc(E_IWB);
  endtask
  task automatic br(input logic [5:0] op, input logic bt);
    pre(op, 6'h00);
    branch_taken = bt;
    cyc(v(bt, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 2'b01, 0, 0));
    branch_taken = 1'b0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc(E_F);
    cyc(E_F);
    rst = 1'b0;
    pre(OP_RTYPE, 6'h21); cyc(E_RE); cyc(E_RWB);
    pre(OP_LW, 6'h00); cyc(E_MA); cyc(E_MR); cyc(E_MR); cyc(E_MWB);
    pre(OP_SW, 6'h00); cyc(E_MA); cyc(E_MW);
    br(OP_BEQ, 1'b0);
    br(OP_BEQ, 1'b1);
    br(6'h05, 1'b1);
    br(OP_REGIMM, 1'b0);
    br(OP_BGTZ, 1'b1);
    iexec(OP_ORI, 1'b0);
    iexec(OP_ADDIU, 1'b1);
    iexec(6'h0B, 1'b1);
    iexec(OP_ANDI, 1'b0);
    iexec(OP_XORI, 1'b0);
    pre(OP_J, 6'h00); cyc(E_J);
    pre(OP_JAL, 6'h00); cyc(E_JAL);
    pre(OP_RTYPE, FUNCT_JR); cyc(E_JR);
    pre(6'h3E, 6'h00);
    pre(6'h08, 6'h00);
    pre(OP_HALT, 6'h00);
    for (int i = 0; i < 100; i++) cyc(E_H);
    rst = 1'b1;
    cyc(E_F);
    rst = 1'b0;
    pre(OP_LW, 6'h00); cyc(E_MA); cyc(E_MR);
    rst = 1'b1;
    cyc(E_F);
    rst = 1'b0;
    cyc(E_F);
    cyc(E_FW);
    mon_en = 1'b0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected words left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
